// File: rtl/reset_sequencer_if.sv
// Software reset request/acknowledge handshake between a requester and reset_sequencer.
interface reset_sequencer_if #(
    parameter int NUM_DOMAINS = 4
);
    logic                   sw_rst_req;
    logic [NUM_DOMAINS-1:0] sw_rst_mask;
    logic                   sw_rst_ack;

    modport master (
        output sw_rst_req,
        output sw_rst_mask,
        input  sw_rst_ack
    );

    modport slave (
        input  sw_rst_req,
        input  sw_rst_mask,
        output sw_rst_ack
    );
endinterface

// File: rtl/reset_sequencer.sv
// Staged per-domain reset release after system reset, plus software reset of any domain subset.
// Optional macro RST_SEQ_INIT_WAIT_EN adds dom_init_done gating of each subsequent release.
module reset_sequencer #(
    parameter int NUM_DOMAINS = 4,
    parameter int STAGE_DELAY = 16,
    parameter int HOLD_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   sync_rst_n,
    reset_sequencer_if.slave       sw_if,
`ifdef RST_SEQ_INIT_WAIT_EN
    input  logic [NUM_DOMAINS-1:0] dom_init_done,
`endif
    output logic [NUM_DOMAINS-1:0] dom_rst_n,
    output logic                   seq_busy,
    output logic                   seq_done
);

    localparam int CNT_MAX = (STAGE_DELAY > HOLD_CYCLES) ? STAGE_DELAY : HOLD_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0]          CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0]          CNT_ONE    = CW'(1);
    localparam logic [CW-1:0]          STAGE_LAST = CW'(STAGE_DELAY - 1);
    localparam logic [CW-1:0]          HOLD_LAST  = CW'(HOLD_CYCLES - 1);
    localparam logic [NUM_DOMAINS-1:0] DOM_ZERO   = {NUM_DOMAINS{1'b0}};
    localparam logic [NUM_DOMAINS-1:0] DOM_ONES   = {NUM_DOMAINS{1'b1}};
    localparam logic [NUM_DOMAINS-1:0] DOM_ONE    = NUM_DOMAINS'(1);

    typedef enum logic [1:0] {
        ST_RELEASE = 2'd0,
        ST_IDLE    = 2'd1,
        ST_HOLD    = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [NUM_DOMAINS-1:0] pending_q, pending_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic                   ack_q, ack_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;

    logic [NUM_DOMAINS-1:0] low_oh_s;
    logic [NUM_DOMAINS-1:0] pending_rest_s;
    logic                   init_ok_s;
    logic                   fin_ok_s;

    // Two's-complement trick isolates the lowest pending domain, so empty slots cost nothing.
    assign low_oh_s       = pending_q & (~pending_q + DOM_ONE);
    assign pending_rest_s = pending_q & ~low_oh_s;

`ifdef RST_SEQ_INIT_WAIT_EN
    logic                   gate_q, gate_d;
    logic [NUM_DOMAINS-1:0] last_oh_q, last_oh_d;

    assign init_ok_s = !gate_q || ((dom_init_done & last_oh_q) != DOM_ZERO);
    assign fin_ok_s  = (dom_init_done & low_oh_s) != DOM_ZERO;
`else
    assign init_ok_s = 1'b1;
    assign fin_ok_s  = 1'b1;
`endif

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        cnt_d     = cnt_q;
        dom_d     = dom_q;
        ack_d     = 1'b0;
        done_d    = 1'b0;
        busy_d    = busy_q;
`ifdef RST_SEQ_INIT_WAIT_EN
        gate_d    = gate_q;
        last_oh_d = last_oh_q;
`endif
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                // ack_q guard keeps the acknowledge a strict single-cycle pulse.
                if (sw_if.sw_rst_req && !ack_q) begin
                    ack_d = 1'b1;
                    if (sw_if.sw_rst_mask != DOM_ZERO) begin
                        dom_d     = dom_q & ~sw_if.sw_rst_mask;
                        pending_d = sw_if.sw_rst_mask;
                        cnt_d     = CNT_ZERO;
                        state_d   = ST_HOLD;
                        busy_d    = 1'b1;
`ifdef RST_SEQ_INIT_WAIT_EN
                        gate_d    = 1'b0;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = CNT_ZERO;
                    state_d = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RELEASE: begin
                if (!init_ok_s) begin
                    cnt_d = CNT_ZERO;
                end else if (pending_q == DOM_ZERO) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (cnt_q == STAGE_LAST) begin
                    cnt_d     = CNT_ZERO;
                    dom_d     = dom_q | low_oh_s;
                    pending_d = pending_rest_s;
`ifdef RST_SEQ_INIT_WAIT_EN
                    gate_d    = 1'b1;
                    last_oh_d = low_oh_s;
`endif
                    if ((pending_rest_s == DOM_ZERO) && fin_ok_s) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d   = ST_RELEASE;
                pending_d = DOM_ONES;
                cnt_d     = CNT_ZERO;
                dom_d     = DOM_ZERO;
                busy_d    = 1'b1;
            end
        endcase
    end

    // State and registered outputs; reset re-arms the full power-up release sequence.
    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            state_q   <= ST_RELEASE;
            pending_q <= DOM_ONES;
            cnt_q     <= CNT_ZERO;
            dom_q     <= DOM_ZERO;
            ack_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b1;
`ifdef RST_SEQ_INIT_WAIT_EN
            gate_q    <= 1'b0;
            last_oh_q <= DOM_ZERO;
`endif
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            dom_q     <= dom_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
`ifdef RST_SEQ_INIT_WAIT_EN
            gate_q    <= gate_d;
            last_oh_q <= last_oh_d;
`endif
        end
    end

    assign sw_if.sw_rst_ack = ack_q;
    assign dom_rst_n        = dom_q;
    assign seq_busy         = busy_q;
    assign seq_done         = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: timestamp-based reference model plus literal timing pins.
module tb_reset_sequencer;
    localparam int N = 4;
    localparam int S = 16;
    localparam int H = 8;

    logic         clk = 1'b0;
    logic         sync_rst_n;
    logic [N-1:0] dom_rst_n;
    logic         seq_busy;
    logic         seq_done;

    reset_sequencer_if #(.NUM_DOMAINS(N)) sw_if ();

    reset_sequencer #(.NUM_DOMAINS(N), .STAGE_DELAY(S), .HOLD_CYCLES(H)) dut (
        .clk           (clk),
        .sync_rst_n    (sync_rst_n),
        .sw_if         (sw_if),
`ifdef RST_SEQ_INIT_WAIT_EN
        .dom_init_done ({N{1'b1}}),
`endif
        .dom_rst_n     (dom_rst_n),
        .seq_busy      (seq_busy),
        .seq_done      (seq_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs as seen by the DUT at each rising edge.
    logic         s_rst;
    logic         s_req;
    logic [N-1:0] s_mask;
    logic         seen_edge = 1'b0;

    always @(posedge clk) begin
        s_rst     <= sync_rst_n;
        s_req     <= sw_if.sw_rst_req;
        s_mask    <= sw_if.sw_rst_mask;
        seen_edge <= 1'b1;
    end

    // Reference model: each release and the done pulse are scheduled as absolute edge numbers.
    int           e = 0;
    bit           armed = 1'b1;
    bit           m_valid = 1'b0;
    logic [N-1:0] m_dom = '0;
    bit           m_ack = 1'b0;
    bit           m_done = 1'b0;
    bit           m_busy = 1'b1;
    int           rel_at [N];
    int           done_at = -1;
    int           n_sel;
    bit           prev_ack;
    bit           prev_busy;

    always @(negedge clk) begin
        if (seen_edge) begin
            e++;
            prev_ack  = m_ack;
            prev_busy = m_busy;
            m_ack     = 1'b0;
            m_done    = 1'b0;
            if (s_rst !== 1'b1) begin
                m_valid = 1'b1;
                m_dom   = '0;
                m_busy  = 1'b1;
                armed   = 1'b1;
                for (int k = 0; k < N; k++) rel_at[k] = -1;
                done_at = -1;
            end else if (m_valid) begin
                if (armed) begin
                    armed = 1'b0;
                    for (int k = 0; k < N; k++) rel_at[k] = e + (k + 1) * S - 1;
                    done_at = e + N * S - 1;
                end
                if (!prev_busy && s_req && !prev_ack) begin
                    m_ack = 1'b1;
                    if (s_mask != '0) begin
                        n_sel = 0;
                        for (int k = 0; k < N; k++) begin
                            if (s_mask[k]) begin
                                n_sel++;
                                m_dom[k]  = 1'b0;
                                rel_at[k] = e + H + n_sel * S;
                                done_at   = e + H + n_sel * S;
                            end
                        end
                        m_busy = 1'b1;
                    end
                end
                for (int k = 0; k < N; k++) begin
                    if (rel_at[k] == e) begin
                        m_dom[k]  = 1'b1;
                        rel_at[k] = -1;
                    end
                end
                if (done_at == e) begin
                    m_done  = 1'b1;
                    m_busy  = 1'b0;
                    done_at = -1;
                end
            end
            if (m_valid) begin
                chk("dom_rst_n", dom_rst_n, m_dom);
                chk("seq_busy", seq_busy, m_busy);
                chk("seq_done", seq_done, m_done);
                chk("sw_rst_ack", sw_if.sw_rst_ack, m_ack);
            end
        end
    end

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (k < 400 && seq_busy !== 1'b0) begin
            @(negedge clk);
            k++;
        end
        chk(name, seq_busy, 1'b0);
    endtask

    int  kc;
    bit  got;

    initial begin
        sync_rst_n         = 1'b0;
        sw_if.sw_rst_req   = 1'b0;
        sw_if.sw_rst_mask  = '0;
        repeat (5) @(negedge clk);

        // Power-up release pins.
        sync_rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("pu_dom_15", dom_rst_n, 4'b0000);
        @(negedge clk);
        chk("pu_dom_16", dom_rst_n, 4'b0001);
        repeat (16) @(negedge clk);
        chk("pu_dom_32", dom_rst_n, 4'b0011);
        repeat (16) @(negedge clk);
        chk("pu_dom_48", dom_rst_n, 4'b0111);
        repeat (15) @(negedge clk);
        chk("pu_busy_63", seq_busy, 1'b1);
        chk("pu_done_63", seq_done, 1'b0);
        @(negedge clk);
        chk("pu_dom_64", dom_rst_n, 4'b1111);
        chk("pu_done_64", seq_done, 1'b1);
        chk("pu_busy_64", seq_busy, 1'b0);
        @(negedge clk);
        chk("pu_done_65", seq_done, 1'b0);

        // Software reset of domains 1 and 3.
        sw_if.sw_rst_mask = 4'b1010;
        sw_if.sw_rst_req  = 1'b1;
        @(negedge clk);
        chk("sw_ack", sw_if.sw_rst_ack, 1'b1);
        chk("sw_dom_hold", dom_rst_n, 4'b0101);
        sw_if.sw_rst_req = 1'b0;
        repeat (23) @(negedge clk);
        chk("sw_dom_23", dom_rst_n, 4'b0101);
        @(negedge clk);
        chk("sw_dom_24", dom_rst_n, 4'b0111);
        repeat (15) @(negedge clk);
        chk("sw_dom_39", dom_rst_n, 4'b0111);
        @(negedge clk);
        chk("sw_dom_40", dom_rst_n, 4'b1111);
        chk("sw_done_40", seq_done, 1'b1);

        // Zero-mask request.
        @(negedge clk);
        sw_if.sw_rst_mask = 4'b0000;
        sw_if.sw_rst_req  = 1'b1;
        @(negedge clk);
        chk("zm_ack", sw_if.sw_rst_ack, 1'b1);
        chk("zm_dom", dom_rst_n, 4'b1111);
        chk("zm_busy", seq_busy, 1'b0);
        sw_if.sw_rst_req = 1'b0;
        @(negedge clk);
        chk("zm_ack_gone", sw_if.sw_rst_ack, 1'b0);
        repeat (5) @(negedge clk);

        // Request held while the power-up sequence is running.
        sync_rst_n = 1'b0;
        repeat (3) @(negedge clk);
        sync_rst_n = 1'b1;
        repeat (10) @(negedge clk);
        sw_if.sw_rst_mask = 4'b0110;
        sw_if.sw_rst_req  = 1'b1;
        kc  = 10;
        got = 1'b0;
        while (kc < 300 && !got) begin
            @(negedge clk);
            kc++;
            if (sw_if.sw_rst_ack === 1'b1) got = 1'b1;
        end
        sw_if.sw_rst_req = 1'b0;
        chk("busy_req_ack_cycle", kc, 65);
        wait_idle("busy_req_idle");

        // Reset in the middle of the power-up sequence.
        sync_rst_n = 1'b0;
        repeat (2) @(negedge clk);
        sync_rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("mid_dom_40", dom_rst_n, 4'b0011);
        sync_rst_n = 1'b0;
        @(negedge clk);
        chk("mid_dom_rst", dom_rst_n, 4'b0000);
        sync_rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("mid_dom_15", dom_rst_n, 4'b0000);
        @(negedge clk);
        chk("mid_dom_16", dom_rst_n, 4'b0001);
        wait_idle("mid_idle");

        // Randomized requests, gaps and occasional resets against the model.
        for (int it = 0; it < 40; it++) begin
            repeat ($urandom_range(0, 6)) @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                sync_rst_n = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                sync_rst_n = 1'b1;
            end
            sw_if.sw_rst_mask = N'($urandom_range(0, 15));
            sw_if.sw_rst_req  = 1'b1;
            kc  = 0;
            got = 1'b0;
            while (kc < 400 && !got) begin
                @(negedge clk);
                kc++;
                if (sw_if.sw_rst_ack === 1'b1) got = 1'b1;
            end
            sw_if.sw_rst_req = 1'b0;
            chk("rand_ack_seen", got, 1'b1);
        end
        wait_idle("rand_final_idle");
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
